// File: rtl/spi_defines_pkg.sv
// spi_defines_pkg: shared SPI transmit-path types and default word width / chip-select timing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CS_SETUP_DEF
`define CS_SETUP_DEF 2
`endif
`ifndef CS_HOLD_DEF
`define CS_HOLD_DEF 2
`endif
package spi_defines_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACTIVE, ARB_HOLD} arb_state_t;
  function automatic int rr_next(int id, int n);
    return (id + 1) % n;
  endfunction
endpackage

// File: rtl/spi_tx_arbiter_rr_arbiter_core.sv
// rr_arbiter_core: picks the first request at or above ptr, wrapping, as one-hot grant plus index.
module rr_arbiter_core #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_vec,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      idx = req_vec[j] ? j : idx;
    end
    grant[idx] = |req_vec;
  end
  assign valid = |req_vec;
endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin share of one spi_serializer among NUM_REQ FIFOs with per-requester cs_n.
// Define SPI_ARB_BURST_EN to keep cs_n low for up to BURST_LEN words per grant.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CS_SETUP_DEF
`define CS_SETUP_DEF 2
`endif
`ifndef CS_HOLD_DEF
`define CS_HOLD_DEF 2
`endif
module spi_tx_arbiter
  import spi_defines_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CS_SETUP = `CS_SETUP_DEF,
  parameter int CS_HOLD = `CS_HOLD_DEF
`ifdef SPI_ARB_BURST_EN
  , parameter int BURST_LEN = 4
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_empty,
  input  logic [NUM_REQ-1:0]            req_full,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_read_data,
  output logic [NUM_REQ-1:0]            req_read_en,
  output logic                          ser_empty,
  output logic                          ser_full,
  output logic [DATA_WIDTH-1:0]         ser_read_data,
  input  logic                          ser_read_en,
  input  logic                          ser_done,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int W = $clog2(NUM_REQ);
  arb_state_t state;
  logic [3:0] cnt;
  logic [W-1:0] ptr, pick;
  logic [NUM_REQ-1:0] req_vec, grant;
  logic valid, seen_rd, act;
  logic [DATA_WIDTH-1:0] heads [NUM_REQ];
`ifdef SPI_ARB_BURST_EN
  logic [3:0] words_sent;
`endif
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_head
    assign heads[i] = req_read_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign req_vec = ~req_empty | req_full;
  assign act = state == ARB_ACTIVE;
  assign busy = state != ARB_IDLE;
  // Once the word is taken, hide the FIFO so the serializer idles after COMPLETE.
  assign ser_empty = act && !seen_rd ? req_empty[grant_id] : 1'b1;
  assign ser_full = act && !seen_rd ? req_full[grant_id] : 1'b0;
  assign ser_read_data = act ? heads[grant_id] : '0;
  assign req_read_en = act && ser_read_en ? NUM_REQ'(1) << grant_id : '0;
  rr_arbiter_core #(.N(NUM_REQ)) u_rr (
    .req_vec(req_vec),
    .ptr(ptr),
    .grant(grant),
    .idx(pick),
    .valid(valid)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt <= '0;
      ptr <= '0;
      grant_id <= '0;
      cs_n <= '1;
      seen_rd <= 1'b0;
`ifdef SPI_ARB_BURST_EN
      words_sent <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: if (valid) begin
          grant_id <= pick;
          cs_n <= ~grant;
          cnt <= '0;
          seen_rd <= 1'b0;
`ifdef SPI_ARB_BURST_EN
          words_sent <= '0;
`endif
          state <= ARB_SETUP;
        end
        ARB_SETUP: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(CS_SETUP - 1)) begin
            cnt <= '0;
            state <= req_empty[grant_id] ? ARB_HOLD : ARB_ACTIVE;
          end
        end
        ARB_ACTIVE: begin
          seen_rd <= seen_rd | ser_read_en;
`ifdef SPI_ARB_BURST_EN
          words_sent <= words_sent + 4'(ser_read_en);
          if (ser_done) begin
            if (!req_empty[grant_id] && words_sent < 4'(BURST_LEN)) seen_rd <= 1'b0;
            else state <= ARB_HOLD;
          end
`else
          if (ser_done) state <= ARB_HOLD;
`endif
        end
        ARB_HOLD: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(CS_HOLD - 1)) begin
            cnt <= '0;
            cs_n <= '1;
            ptr <= W'(rr_next(int'(grant_id), NUM_REQ));
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one spi_serializer between NUM_REQ transmit FIFOs using round-robin arbitration.
- Presents the granted FIFO's full/empty/read_data to the serializer and routes read_en back to that FIFO only.
- Drives a per-requester active-low chip select, with programmable setup and hold gaps, around each transfer.
- Sits between the FIFO bank and spi_serializer in the SPI transmit path.

Parameters:
- NUM_REQ, 4, number of requester FIFOs / chip selects (2..8).
- DATA_WIDTH, `DATA_WIDTH, serializer word width.
- CS_SETUP, 2, clk cycles cs_n is low before the serializer is released (1..15).
- CS_HOLD, 2, clk cycles cs_n stays low after ser_done (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_empty  in  NUM_REQ  FIFO empty flags
- req_full  in  NUM_REQ  FIFO full flags
- req_read_data  in  NUM_REQ*DATA_WIDTH  FIFO heads; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_read_en  out  NUM_REQ  FIFO pop strobes
- ser_empty  out  1  to serializer empty
- ser_full  out  1  to serializer full
- ser_read_data  out  DATA_WIDTH  to serializer read_data
- ser_read_en  in  1  from serializer read_en
- ser_done  in  1  from serializer done
- cs_n  out  NUM_REQ  chip selects, active-low
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in every state except ARB_IDLE

Behaviour:
- Reset values:
  - cs_n all 1; req_read_en 0; ser_empty 1; ser_full 0; ser_read_data 0; grant_id 0; busy 0.
  - State ARB_IDLE; round-robin pointer 0, so requester 0 has highest priority.
- Request vector: req_vec[i] = !req_empty[i] || req_full[i].
- FSM states: ARB_IDLE, ARB_SETUP, ARB_ACTIVE, ARB_HOLD.
- ARB_IDLE:
  - If req_vec != 0, pick the first set bit searching from the pointer upward with wrap.
  - Register grant_id and go to ARB_SETUP.
  - cs_n[grant_id] goes low on that same edge.
- ARB_SETUP: counts CS_SETUP cycles, then goes to ARB_ACTIVE.
- ARB_ACTIVE:
  - ser_empty = req_empty[grant_id] and ser_full = req_full[grant_id] until ser_read_en is first seen.
  - From the cycle after ser_read_en, force ser_empty = 1 and ser_full = 0 so the serializer idles after COMPLETE.
  - ser_read_data = combinational mux of req_read_data[grant_id] during ARB_ACTIVE; 0 otherwise.
  - req_read_en[grant_id] = ser_read_en during ARB_ACTIVE; every other bit is 0. At most one req_read_en bit is high at any time.
  - On ser_done, go to ARB_HOLD.
- ARB_HOLD:
  - Counts CS_HOLD cycles, then deasserts cs_n[grant_id].
  - Sets pointer = grant_id+1 (mod NUM_REQ) and returns to ARB_IDLE.
  - Guarantees at least one cycle with all cs_n high between grants.
- Outside ARB_ACTIVE, ser_empty = 1 and ser_full = 0, so the serializer never starts outside a grant.
- cs_n: at most one bit low at any time; the low bit always equals grant_id.
- Granted FIFO empties during setup (external pop): after CS_SETUP elapses with ser_empty still 1, abort to ARB_HOLD with no transfer.
- Any ser_read_en or ser_done outside ARB_ACTIVE is ignored.
- Requests arriving while busy wait for ARB_IDLE; no preemption.
- Simultaneous requests resolve by round-robin order only.
- rst mid-operation forces reset values immediately; the serializer shares rst.

Optional Feature:
- Macro: SPI_ARB_BURST_EN.
- Defined:
  - Parameter BURST_LEN (default 4) applies.
  - On ser_done in ARB_ACTIVE, if the granted FIFO is still non-empty and words_sent < BURST_LEN, stay in ARB_ACTIVE with cs_n held low.
  - Re-present the FIFO status so the next word starts. words_sent is a 4-bit counter, cleared on grant.
- Undefined: exactly one word per grant, as described above.

Decomposition:
- spi_defines_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_SETUP, ARB_ACTIVE, ARB_HOLD}
  - `CS_SETUP_DEF and `CS_HOLD_DEF constants
- One sub-module, rr_arbiter_core: combinational round-robin priority pick from req_vec and pointer, producing a one-hot grant plus index.

Test Plan:
1. Reset, then req_empty=4'b1110 with req 0 head 8'hA5 → cs_n=4'b1110 two cycles before serializer LOAD; req_read_en[0] pulses once; mosi carries A5 MSB-first; cs_n=4'b1111 two cycles after done.
2. All four FIFOs hold one word from reset → grants in order 0,1,2,3; cs_n never has two bits low; busy drops after the fourth hold.
3. After a grant to 2, requesters 0 and 3 pending → next grant is 3, then 0 (wrap).
4. req 1 non-empty at IDLE, externally popped empty during ARB_SETUP → no req_read_en, no done, return to ARB_IDLE with cs_n=4'b1111.
5. rst asserted mid-SHIFT of a grant to 1 → all outputs reach reset values without waiting for a clock edge; after release, requester 0 has priority.
6. With SPI_ARB_BURST_EN and BURST_LEN=4, req 0 holding 6 words → 4 words under one continuous cs_n low, then release; next grant to req 0 sends the remaining 2.
